gcn_matrix_loader: RTL
======================

// Module: gcn_matrix_loader
// PURPOSE
//  Streaming writer that fills the feature (A, ROWS_A x COLS_A) and weight (B, COLS_A x COLS_B) buffers consumed by the GCN matrix multiplier.
//  Accepts one element per beat over valid/ready (A row-major, then B row-major) and issues one buffer write per accepted beat.
//  Checks frame length against s_last; signals done/err to the control sequencer.
// PARAMETERS
//  ROWS_A  6   rows of A (= rows of result)
//  COLS_A  96  columns of A = rows of B
//  COLS_B  3   columns of B
//  DW      6   element width, bits
// PORTS
//  clk      in   1        clock, all logic on rising edge
//  rst      in   1        asynchronous, active-high reset
//  start    in   1        begin a new frame; honoured only in IDLE
//  s_valid  in   1        input element valid
//  s_ready  out  1        loader accepts element
//  s_data   in   DW       element value
//  s_last   in   1        marks final element of frame (last B element)
//  a_we     out  1        write strobe, A buffer
//  a_addr   out  AWA      A address = row*COLS_A+col; AWA=$clog2(ROWS_A*COLS_A)
//  a_wdata  out  DW       A write data
//  b_we     out  1        write strobe, B buffer
//  b_addr   out  AWB      B address = row*COLS_B+col; AWB=$clog2(COLS_A*COLS_B)
//  b_wdata  out  DW       B write data
//  busy     out  1        frame in progress (LOAD_A or LOAD_B)
//  done     out  1        1-cycle pulse at frame end (good or bad)
//  err      out  1        sticky frame error; cleared by accepted start
// BEHAVIOUR
//  Reset: state IDLE; s_ready, a_we, b_we, busy, done, err = 0; addrs, wdata, counter = 0. Buffer contents untouched.
//  NA = ROWS_A*COLS_A (576), NB = COLS_A*COLS_B (288). Beat = s_valid && s_ready.
//  FSM IDLE -> LOAD_A -> LOAD_B -> IDLE.
//   IDLE: s_ready=0. start -> LOAD_A, counter=0, err=0. Beats impossible.
//   LOAD_A: s_ready=1 (combinational from state). Beat k (0..NA-1): a_we=1 next cycle,
//     a_addr=k, a_wdata=s_data. Beat NA-1 -> LOAD_B, counter=0.
//   LOAD_B: s_ready=1. Beat k (0..NB-1): b_we=1 next cycle, b_addr=k, b_wdata=s_data.
//     Beat NB-1 -> IDLE, done=1 next cycle.
//  Write latency: exactly 1 cycle from beat to registered we/addr/wdata; strobe held 1 cycle per beat.
//  No beat in a cycle -> we=0 that cycle; addr/wdata hold last value. s_valid gaps arbitrary.
//  s_last checks (per beat):
//   s_last=1 before final B beat (incl. any A beat): element written, err=1, done=1 next cycle, -> IDLE (frame truncated).
//   Final B beat with s_last=0: element written, err=1, normal completion otherwise.
//  done and the final write strobe are asserted in the same cycle.
//  busy=1 exactly in LOAD_A/LOAD_B; start while busy ignored (no restart, err unchanged).
//  start and done-generating beat can't coincide (start only sampled in IDLE).
//  Reset mid-frame: immediate return to reset values; partially written buffers keep data; next start reloads from address 0.
//  Counters sized to hold NA-1 / NB-1; never wrap within a frame.
// TESTING
//  1 Reset, start, stream 864 beats s_data=k%64, s_valid=1, s_last on beat 863 -> 576 a_we with a_addr 0..575, 288 b_we with b_addr 0..287, data matches, done pulse once, err=0.
//  2 Same frame with s_valid random 50% duty -> identical write sequence, one write per beat, no write on idle cycles.
//  3 s_last=1 on beat 100 -> a_we for addr 100 then done=1, err=1, s_ready=0; beats 101+ not accepted, b_we never pulses.
//  4 Full frame without s_last -> all 864 writes, done=1 with err=1; next start clears err to 0.
//  5 Pulse start at beat 300 of A -> ignored; frame completes normally, a_addr continues 301.. without restart.
//  6 Assert rst at beat 400 -> all outputs 0 same cycle; new start + full frame -> a_addr restarts at 0, done, err=0.

Source files
------------

// File: rtl/gcn_matrix_loader.sv
// gcn_matrix_loader
//   Streaming writer that fills the feature buffer A (ROWS_A x COLS_A) and the
//   weight buffer B (COLS_A x COLS_B) used by the GCN matrix multiplier.
//   Elements arrive one per beat over valid/ready, A row-major first, then B
//   row-major. Every accepted beat produces exactly one registered buffer write
//   one cycle later. The frame length is checked against s_last, and done/err
//   are reported to the control sequencer.
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst      : asynchronous active-high reset
//   start    : begin a new frame (only looked at while idle)
//   s_valid  : input element valid
//   s_ready  : loader can accept an element (high while loading)
//   s_data   : element value
//   s_last   : marks the final element of the frame (last B element)
//   a_we     : A buffer write strobe
//   a_addr   : A buffer address (row*COLS_A+col)
//   a_wdata  : A buffer write data
//   b_we     : B buffer write strobe
//   b_addr   : B buffer address (row*COLS_B+col)
//   b_wdata  : B buffer write data
//   busy     : frame in progress
//   done     : one-cycle pulse at the end of a frame, good or bad
//   err      : sticky frame error, cleared when a new frame starts
module gcn_matrix_loader #(
  parameter int ROWS_A = 6,
  parameter int COLS_A = 96,
  parameter int COLS_B = 3,
  parameter int DW     = 6,
  localparam int NA    = ROWS_A * COLS_A,
  localparam int NB    = COLS_A * COLS_B,
  localparam int AWA   = $clog2(NA),
  localparam int AWB   = $clog2(NB)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [DW-1:0]  s_data,
  input  logic           s_last,
  output logic           a_we,
  output logic [AWA-1:0] a_addr,
  output logic [DW-1:0]  a_wdata,
  output logic           b_we,
  output logic [AWB-1:0] b_addr,
  output logic [DW-1:0]  b_wdata,
  output logic           busy,
  output logic           done,
  output logic           err
);

  // One counter serves both phases, so it is sized for the larger buffer.
  localparam int CW = (AWA > AWB) ? AWA : AWB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2
  } loaderState_t;

  loaderState_t state;
  logic [CW-1:0] elemCount;
  logic          beat;

  // The loader is ready in both load phases and never while idle, so a beat is
  // simply a valid element presented during loading.
  assign s_ready = (state == LOAD_A) || (state == LOAD_B);
  assign busy    = s_ready;
  assign beat    = s_valid && s_ready;

  // Main sequencer. Write strobes and done are single-cycle pulses, so they are
  // defaulted low every cycle; addresses and data hold their last value between
  // writes. An early s_last truncates the frame but the element carrying it is
  // still written. The final B element always ends the frame and only raises
  // err if s_last was missing on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      elemCount <= '0;
      a_we      <= 1'b0;
      a_addr    <= '0;
      a_wdata   <= '0;
      b_we      <= 1'b0;
      b_addr    <= '0;
      b_wdata   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      a_we <= 1'b0;
      b_we <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD_A;
            elemCount <= '0;
            err       <= 1'b0;
          end
        end
        LOAD_A: begin
          if (beat) begin
            a_we    <= 1'b1;
            a_addr  <= elemCount[AWA-1:0];
            a_wdata <= s_data;
            if (s_last) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= IDLE;
            end else if (elemCount == CW'(NA - 1)) begin
              state     <= LOAD_B;
              elemCount <= '0;
            end else begin
              elemCount <= elemCount + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (beat) begin
            b_we    <= 1'b1;
            b_addr  <= elemCount[AWB-1:0];
            b_wdata <= s_data;
            if (elemCount == CW'(NB - 1)) begin
              done  <= 1'b1;
              state <= IDLE;
              if (!s_last) begin
                err <= 1'b1;
              end
            end else if (s_last) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              elemCount <= elemCount + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
